// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: shared FSM encoding and endpoint sizing constants for the USB FS endpoint arbiters
package usb_fs_pkg;
  localparam int MAX_EPS = 16;
  localparam int EP_IDX_W = $clog2(MAX_EPS);
  typedef enum logic [1:0] {IDLE, LOCK, GAP} dist_state_e;
endpackage

// File: rtl/usb_fs_rr_pick.sv
// usb_fs_rr_pick: combinational round-robin picker, first requester after the last winner
module usb_fs_rr_pick
  import usb_fs_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [N-1:0]        req,
  input  logic [EP_IDX_W-1:0] last,
  output logic [N-1:0]        onehot,
  output logic [EP_IDX_W-1:0] idx,
  output logic                found
);
  // scan last+1 .. last+N with a single wrap so the index never leaves 0..N-1
  always_comb begin
    int j;
    onehot = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last) + k;
      j = (j >= N) ? j - N : j;
      if (!found && req[j]) begin
        found = 1'b1;
        onehot[j] = 1'b1;
        idx = EP_IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/usb_fs_out_dist.sv
// usb_fs_out_dist: locks the PE OUT byte stream to one endpoint per transfer; optional USB_FS_OUT_DIST_TIMEOUT_EN watchdog
module usb_fs_out_dist
  import usb_fs_pkg::*;
#(
  parameter int NUM_OUT_EPS    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_OUT_EPS-1:0] out_ep_req,
  output logic [NUM_OUT_EPS-1:0] out_ep_grant,
  input  logic [NUM_OUT_EPS-1:0] out_ep_data_get,
  output logic [NUM_OUT_EPS-1:0] out_ep_data_put,
  output logic [7:0]             out_ep_data,
  input  logic [7:0]             pe_out_data,
  input  logic                   pe_out_data_valid,
  output logic                   pe_out_data_get
);
  dist_state_e state, state_n;
  logic [NUM_OUT_EPS-1:0] grant_n, pick_oh, elig;
  logic [EP_IDX_W-1:0] rr_last, rr_n, pick_idx;
  logic pick_found, req_g, get_g, pop, revoke;
  assign req_g = |(out_ep_req & out_ep_grant);
  assign get_g = |(out_ep_data_get & out_ep_grant);
  assign pop = reset_n && state == LOCK && req_g && get_g && pe_out_data_valid;
  assign pe_out_data_get = pop;
`ifdef USB_FS_OUT_DIST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic [NUM_OUT_EPS-1:0] revoked;
  assign revoke = state == LOCK && cnt == CW'(TIMEOUT_CYCLES);
  assign elig = out_ep_req & ~revoked;
  // idle-grant watchdog; a revoked endpoint stays excluded until it drops req
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      revoked <= '0;
    end else begin
      cnt <= (state == LOCK && !pop && !revoke) ? cnt + 1'b1 : '0;
      revoked <= (revoked | (revoke ? out_ep_grant : '0)) & out_ep_req;
    end
  end
`else
  assign revoke = TIMEOUT_CYCLES < 0;
  assign elig = out_ep_req;
`endif
  usb_fs_rr_pick #(.N(NUM_OUT_EPS)) u_pick (
    .req   (elig),
    .last  (rr_last),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .found (pick_found)
  );
  // next-state: pick in IDLE, hold in LOCK, one dead cycle in GAP
  always_comb begin
    state_n = state;
    grant_n = out_ep_grant;
    rr_n = rr_last;
    case (state)
      IDLE: if (pick_found) begin
        state_n = LOCK;
        grant_n = pick_oh;
        rr_n = pick_idx;
      end
      LOCK: if (!req_g || revoke) begin
        state_n = GAP;
        grant_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, grant and registered byte return
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      out_ep_grant <= '0;
      rr_last <= EP_IDX_W'(NUM_OUT_EPS - 1);
      out_ep_data_put <= '0;
      out_ep_data <= '0;
    end else begin
      state <= state_n;
      out_ep_grant <= grant_n;
      rr_last <= rr_n;
      out_ep_data_put <= pop ? out_ep_grant : '0;
      out_ep_data <= pop ? pe_out_data : out_ep_data;
    end
  end
endmodule
